eth_cmd_regs: RTL and testbench

Command register bank and trigger timer placed directly downstream of the Ethernet command parser in the AD9226/RGMII path. It accepts decoded commands (`cmdvalid`, 8-bit address, 32-bit data) and applies them to scan-control registers. It generates start, trigger and device-reset pulses for the acquisition logic. It can optionally return an echo/readback response toward the UDP TX path.

---
 rtl/eth_cmd_pkg.sv | 40 ++++
 rtl/trig_timer.sv | 64 ++++++
 rtl/eth_cmd_regs.sv | 274 +++++++++++++++++++++++++++
 tb/tb_eth_cmd_regs.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_cmd_pkg.sv
// -----------------------------------------------------------------------------
// eth_cmd_pkg
// Shared constants and types for the Ethernet command register bank:
// command address map, FSM state encoding, CTRL bit positions, field widths
// and the captured-command payload struct.
// -----------------------------------------------------------------------------
package eth_cmd_pkg;

    localparam int unsigned ADDR_W       = 8;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned SAMPLE_LEN_W = 14;
    localparam int unsigned GAIN_W       = 12;
    localparam int unsigned DROP_W       = 8;
    localparam int unsigned RST_CNT_W    = 8;

    localparam logic [ADDR_W-1:0] ADDR_CTRL        = 8'h01;
    localparam logic [ADDR_W-1:0] ADDR_SAMPLE_LEN  = 8'h02;
    localparam logic [ADDR_W-1:0] ADDR_TRIG_PERIOD = 8'h03;
    localparam logic [ADDR_W-1:0] ADDR_GAIN        = 8'h04;
    localparam logic [ADDR_W-1:0] ADDR_START       = 8'h10;
    localparam logic [ADDR_W-1:0] ADDR_SOFT_RST    = 8'h11;
    localparam logic [ADDR_W-1:0] ADDR_READ        = 8'h20;

    localparam logic [DATA_W-1:0] BAD_ADDR_DATA = 32'hDEAD_BEEF;

    localparam int unsigned CTRL_RUN_BIT  = 0;
    localparam int unsigned CTRL_CONT_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/trig_timer.sv
// -----------------------------------------------------------------------------
// trig_timer
// Acquisition trigger generator. Counts clk cycles while running in continuous
// mode and emits a one-cycle trigger every period_i cycles; a start strobe
// forces a trigger on the following cycle and restarts the count.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   run_i          : counter enable (counter held at 0 when low)
//   cont_i         : periodic (continuous) triggering enable
//   period_i       : trigger period in clk cycles (already clamped upstream)
//   start_i        : one-cycle software start
//   trig_pulse_o   : registered one-cycle trigger
// -----------------------------------------------------------------------------
module trig_timer
    import eth_cmd_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run_i,
    input  logic              cont_i,
    input  logic [DATA_W-1:0] period_i,
    input  logic              start_i,
    output logic              trig_pulse_o
);

    logic [DATA_W-1:0] tcnt_q, tcnt_d;
    logic              trig_q, trig_d;
    logic              at_end;

    // >= rather than == so a period shortened mid-count fires and wraps at once
    assign at_end = (tcnt_q >= (period_i - DATA_W'(1)));

    // Next count / trigger
    always_comb begin
        tcnt_d = tcnt_q;
        trig_d = 1'b0;
        if (!run_i || start_i) begin
            tcnt_d = '0;
        end else if (cont_i) begin
            if (at_end) begin
                tcnt_d = '0;
                trig_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + DATA_W'(1);
            end
        end
        if (start_i) begin
            trig_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tcnt_q <= '0;
            trig_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            trig_q <= trig_d;
        end
    end

    assign trig_pulse_o = trig_q;

endmodule

// File: rtl/eth_cmd_regs.sv
// -----------------------------------------------------------------------------
// eth_cmd_regs
// Command register bank fed by the Ethernet command parser. Each rising edge
// of cmdvalid is one command; it is executed against the scan-control
// registers, may raise start/soft-reset pulses, and optionally produces an
// echo/readback response for the UDP TX path. A one-deep pending slot absorbs
// a command that arrives while busy; further ones are dropped and counted.
//
// Build option: ETH_CMD_ECHO_EN enables the RESP state, the response channel
// and the READ (0x20) command. Without it the response ports are tied to 0.
//
// Ports:
//   clk, reset_n                  : clock, synchronous active-low reset
//   cmdvalid, address, cmd_data   : decoded command from the parser
//   run, continuous               : CTRL[0], CTRL[1]
//   sample_len, gain_code         : acquisition length / VGA gain code
//   start_pulse, trig_pulse       : one-cycle start and trigger
//   dev_rst                       : stretched soft reset
//   drop_cnt                      : saturating dropped-command count
//   busy                          : FSM not idle
//   rsp_valid, rsp_ready,
//   rsp_addr, rsp_data            : echo/readback response channel
// -----------------------------------------------------------------------------
module eth_cmd_regs
    import eth_cmd_pkg::*;
#(
    parameter int unsigned DEF_SAMPLE_LEN  = 1024,
    parameter int unsigned DEF_TRIG_PERIOD = 50000,
    parameter int unsigned DEF_GAIN        = 12'h800,
    parameter int unsigned MIN_PERIOD      = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cmdvalid,
    input  logic [ADDR_W-1:0]       address,
    input  logic [DATA_W-1:0]       cmd_data,
    output logic                    run,
    output logic                    continuous,
    output logic [SAMPLE_LEN_W-1:0] sample_len,
    output logic [GAIN_W-1:0]       gain_code,
    output logic                    start_pulse,
    output logic                    trig_pulse,
    output logic                    dev_rst,
    output logic [DROP_W-1:0]       drop_cnt,
    output logic                    busy,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ADDR_W-1:0]       rsp_addr,
    output logic [DATA_W-1:0]       rsp_data
);

    state_e                  state_q, state_d;
    logic                    cmdvalid_q;
    logic                    cmd_stb;
    cmd_t                    cur_q, cur_d;
    cmd_t                    pend_q, pend_d;
    logic                    pend_full_q, pend_full_d;
    logic [1:0]              ctrl_q, ctrl_d;
    logic [SAMPLE_LEN_W-1:0] sample_len_q, sample_len_d;
    logic [DATA_W-1:0]       period_q, period_d;
    logic [GAIN_W-1:0]       gain_q, gain_d;
    logic                    start_pulse_q, start_pulse_d;
    logic [RST_CNT_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic                    dev_rst_q, dev_rst_d;
    logic [DROP_W-1:0]       drop_cnt_q, drop_cnt_d;
    logic                    busy_q, busy_d;
    logic [DATA_W-1:0]       exec_data;

`ifdef ETH_CMD_ECHO_EN
    logic                    rsp_valid_q, rsp_valid_d;
    logic [ADDR_W-1:0]       rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;
`endif

    assign cmd_stb = cmdvalid & ~cmdvalid_q;

    // Next-state, register writes and response formation
    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        pend_d        = pend_q;
        pend_full_d   = pend_full_q;
        ctrl_d        = ctrl_q;
        sample_len_d  = sample_len_q;
        period_d      = period_q;
        gain_d        = gain_q;
        start_pulse_d = 1'b0;
        rst_cnt_d     = (rst_cnt_q != '0) ? rst_cnt_q - RST_CNT_W'(1) : '0;
        drop_cnt_d    = drop_cnt_q;
        exec_data     = '0;
`ifdef ETH_CMD_ECHO_EN
        rsp_addr_d    = rsp_addr_q;
        rsp_data_d    = rsp_data_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Pending command goes first; a coincident strobe refills the slot
                if (pend_full_q) begin
                    cur_d       = pend_q;
                    state_d     = ST_EXEC;
                    pend_full_d = cmd_stb;
                    if (cmd_stb) begin
                        pend_d = '{addr: address, data: cmd_data};
                    end
                end else if (cmd_stb) begin
                    cur_d   = '{addr: address, data: cmd_data};
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
`ifdef ETH_CMD_ECHO_EN
                state_d = ST_RESP;
`else
                state_d = ST_IDLE;
`endif
                case (cur_q.addr)
                    ADDR_CTRL: begin
                        ctrl_d    = cur_q.data[1:0];
                        exec_data = DATA_W'(cur_q.data[1:0]);
                    end
                    ADDR_SAMPLE_LEN: begin
                        sample_len_d = (cur_q.data[SAMPLE_LEN_W-1:0] == '0) ?
                                       SAMPLE_LEN_W'(1) : cur_q.data[SAMPLE_LEN_W-1:0];
                        exec_data    = DATA_W'(sample_len_d);
                    end
                    ADDR_TRIG_PERIOD: begin
                        period_d  = (cur_q.data < DATA_W'(MIN_PERIOD)) ?
                                    DATA_W'(MIN_PERIOD) : cur_q.data;
                        exec_data = period_d;
                    end
                    ADDR_GAIN: begin
                        gain_d    = cur_q.data[GAIN_W-1:0];
                        exec_data = DATA_W'(cur_q.data[GAIN_W-1:0]);
                    end
                    ADDR_START: begin
                        start_pulse_d = 1'b1;
                        exec_data     = cur_q.data;
                    end
                    ADDR_SOFT_RST: begin
                        rst_cnt_d = (cur_q.data[RST_CNT_W-1:0] == '0) ?
                                    RST_CNT_W'(1) : cur_q.data[RST_CNT_W-1:0];
                        exec_data = DATA_W'(rst_cnt_d);
                    end
`ifdef ETH_CMD_ECHO_EN
                    ADDR_READ: begin
                        case (cur_q.data[ADDR_W-1:0])
                            ADDR_CTRL:        exec_data = DATA_W'(ctrl_q);
                            ADDR_SAMPLE_LEN:  exec_data = DATA_W'(sample_len_q);
                            ADDR_TRIG_PERIOD: exec_data = period_q;
                            ADDR_GAIN:        exec_data = DATA_W'(gain_q);
                            default:          exec_data = '0;
                        endcase
                    end
`endif
                    default: begin
                        exec_data = BAD_ADDR_DATA;
                    end
                endcase
`ifdef ETH_CMD_ECHO_EN
                rsp_addr_d = cur_q.addr;
                rsp_data_d = exec_data;
`endif
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobe arriving while busy: park it, or drop it if the slot is taken
        if ((state_q != ST_IDLE) && cmd_stb) begin
            if (!pend_full_q) begin
                pend_full_d = 1'b1;
                pend_d      = '{addr: address, data: cmd_data};
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end

        busy_d    = (state_d != ST_IDLE);
        dev_rst_d = (rst_cnt_d != '0);
`ifdef ETH_CMD_ECHO_EN
        rsp_valid_d = (state_d == ST_RESP);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cmdvalid_q    <= 1'b0;
            cur_q         <= '0;
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            ctrl_q        <= '0;
            sample_len_q  <= SAMPLE_LEN_W'(DEF_SAMPLE_LEN);
            period_q      <= DATA_W'(DEF_TRIG_PERIOD);
            gain_q        <= GAIN_W'(DEF_GAIN);
            start_pulse_q <= 1'b0;
            rst_cnt_q     <= '0;
            dev_rst_q     <= 1'b0;
            drop_cnt_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmdvalid_q    <= cmdvalid;
            cur_q         <= cur_d;
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            ctrl_q        <= ctrl_d;
            sample_len_q  <= sample_len_d;
            period_q      <= period_d;
            gain_q        <= gain_d;
            start_pulse_q <= start_pulse_d;
            rst_cnt_q     <= rst_cnt_d;
            dev_rst_q     <= dev_rst_d;
            drop_cnt_q    <= drop_cnt_d;
            busy_q        <= busy_d;
        end
    end

`ifdef ETH_CMD_ECHO_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data  = rsp_data_q;
`else
    // Response channel absent: ready is ignored and the payload is unused
    logic unused_rsp;
    assign unused_rsp = ^{rsp_ready, exec_data};

    assign rsp_valid = 1'b0;
    assign rsp_addr  = '0;
    assign rsp_data  = '0;
`endif

    trig_timer u_trig_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .run_i        (ctrl_q[CTRL_RUN_BIT]),
        .cont_i       (ctrl_q[CTRL_CONT_BIT]),
        .period_i     (period_q),
        .start_i      (start_pulse_q),
        .trig_pulse_o (trig_pulse)
    );

    assign run         = ctrl_q[CTRL_RUN_BIT];
    assign continuous  = ctrl_q[CTRL_CONT_BIT];
    assign sample_len  = sample_len_q;
    assign gain_code   = gain_q;
    assign start_pulse = start_pulse_q;
    assign dev_rst     = dev_rst_q;
    assign drop_cnt    = drop_cnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_eth_cmd_regs.sv
// -----------------------------------------------------------------------------
// tb_eth_cmd_regs
// Self-checking bench for eth_cmd_regs: a table of single-command vectors
// with hand-computed register/response values, followed by directed
// sequences for the timer, start, soft reset, pending/drop and mid-run reset.
// Response-channel expectations follow the ETH_CMD_ECHO_EN build option.
// -----------------------------------------------------------------------------
module tb_eth_cmd_regs;

    logic        clk;
    logic        reset_n;
    logic        cmdvalid;
    logic [7:0]  address;
    logic [31:0] cmd_data;
    logic        run;
    logic        continuous;
    logic [13:0] sample_len;
    logic [11:0] gain_code;
    logic        start_pulse;
    logic        trig_pulse;
    logic        dev_rst;
    logic [7:0]  drop_cnt;
    logic        busy;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_addr;
    logic [31:0] rsp_data;

    int checks   = 0;
    int failures = 0;

    eth_cmd_regs dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmdvalid    (cmdvalid),
        .address     (address),
        .cmd_data    (cmd_data),
        .run         (run),
        .continuous  (continuous),
        .sample_len  (sample_len),
        .gain_code   (gain_code),
        .start_pulse (start_pulse),
        .trig_pulse  (trig_pulse),
        .dev_rst     (dev_rst),
        .drop_cnt    (drop_cnt),
        .busy        (busy),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_addr    (rsp_addr),
        .rsp_data    (rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        run;
        logic        cont;
        logic [13:0] len;
        logic [11:0] gain;
        logic [31:0] rsp;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; leaves time 1 unit after the rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One command: cmdvalid high for one cycle (T), low for one (T+1); returns in T+2
    task automatic send(input logic [7:0] a, input logic [31:0] d);
        address  = a;
        cmd_data = d;
        cmdvalid = 1'b1;
        cycle();
        cmdvalid = 1'b0;
        cycle();
    endtask

    initial begin
        int n;
        int first;
        int last;
        int gap_bad;
        int npulse;

        reset_n   = 1'b0;
        cmdvalid  = 1'b0;
        address   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b1;

        vecs[0]  = '{8'h20, 32'h0000_0004, 1'b0, 1'b0, 14'd1024,  12'h800, 32'h0000_0800};
        vecs[1]  = '{8'h20, 32'h0000_0003, 1'b0, 1'b0, 14'd1024,  12'h800, 32'd50000};
        vecs[2]  = '{8'h02, 32'h0000_0000, 1'b0, 1'b0, 14'd1,     12'h800, 32'd1};
        vecs[3]  = '{8'h02, 32'h0000_3FFF, 1'b0, 1'b0, 14'h3FFF,  12'h800, 32'h0000_3FFF};
        vecs[4]  = '{8'h02, 32'hFFFF_C005, 1'b0, 1'b0, 14'd5,     12'h800, 32'd5};
        vecs[5]  = '{8'h04, 32'h1234_5ABC, 1'b0, 1'b0, 14'd5,     12'hABC, 32'h0000_0ABC};
        vecs[6]  = '{8'h03, 32'd5,         1'b0, 1'b0, 14'd5,     12'hABC, 32'd16};
        vecs[7]  = '{8'h03, 32'd15,        1'b0, 1'b0, 14'd5,     12'hABC, 32'd16};
        vecs[8]  = '{8'h03, 32'd16,        1'b0, 1'b0, 14'd5,     12'hABC, 32'd16};
        vecs[9]  = '{8'h03, 32'd20,        1'b0, 1'b0, 14'd5,     12'hABC, 32'd20};
        vecs[10] = '{8'h20, 32'h0000_0003, 1'b0, 1'b0, 14'd5,     12'hABC, 32'd20};
        vecs[11] = '{8'h20, 32'h0000_0055, 1'b0, 1'b0, 14'd5,     12'hABC, 32'd0};
        vecs[12] = '{8'h7F, 32'h0000_1234, 1'b0, 1'b0, 14'd5,     12'hABC, 32'hDEAD_BEEF};
        vecs[13] = '{8'h01, 32'h0000_0002, 1'b0, 1'b1, 14'd5,     12'hABC, 32'd2};
        vecs[14] = '{8'h01, 32'hFFFF_FFFC, 1'b0, 1'b0, 14'd5,     12'hABC, 32'd0};
        vecs[15] = '{8'h20, 32'h0000_0002, 1'b0, 1'b0, 14'd5,     12'hABC, 32'd5};

        // ---- reset state ----
        repeat (3) cycle();
        check("rst_run",        32'(run),         32'd0);
        check("rst_cont",       32'(continuous),  32'd0);
        check("rst_len",        32'(sample_len),  32'd1024);
        check("rst_gain",       32'(gain_code),   32'h800);
        check("rst_start",      32'(start_pulse), 32'd0);
        check("rst_trig",       32'(trig_pulse),  32'd0);
        check("rst_dev_rst",    32'(dev_rst),     32'd0);
        check("rst_drop",       32'(drop_cnt),    32'd0);
        check("rst_busy",       32'(busy),        32'd0);
        check("rst_rsp_valid",  32'(rsp_valid),   32'd0);
        check("rst_rsp_addr",   32'(rsp_addr),    32'd0);
        check("rst_rsp_data",   rsp_data,         32'd0);
        reset_n = 1'b1;
        cycle();

        // ---- table-driven single commands, checked at T+2 ----
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].addr, vecs[i].data);
            check($sformatf("v%0d_run", i),  32'(run),        32'(vecs[i].run));
            check($sformatf("v%0d_cont", i), 32'(continuous), 32'(vecs[i].cont));
            check($sformatf("v%0d_len", i),  32'(sample_len), 32'(vecs[i].len));
            check($sformatf("v%0d_gain", i), 32'(gain_code),  32'(vecs[i].gain));
`ifdef ETH_CMD_ECHO_EN
            check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("v%0d_rsp_addr", i),  32'(rsp_addr),  32'(vecs[i].addr));
            check($sformatf("v%0d_rsp_data", i),  rsp_data,       vecs[i].rsp);
`else
            check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd0);
            check($sformatf("v%0d_rsp_data", i),  rsp_data,       32'd0);
`endif
            cycle();
        end

        // ---- busy through EXEC (and RESP when echo is built in) ----
        address  = 8'h7F;
        cmd_data = 32'h0;
        cmdvalid = 1'b1;
        cycle();
        check("busy_exec", 32'(busy), 32'd1);
        cmdvalid = 1'b0;
        cycle();
`ifdef ETH_CMD_ECHO_EN
        check("busy_resp", 32'(busy), 32'd1);
`else
        check("busy_after_exec", 32'(busy), 32'd0);
`endif
        cycle();
        check("busy_idle", 32'(busy), 32'd0);

        // ---- periodic triggering, period 20 (set by the table) ----
        send(8'h01, 32'd3);
        check("per_run",  32'(run),        32'd1);
        check("per_cont", 32'(continuous), 32'd1);
        first   = -1;
        last    = -1;
        gap_bad = 0;
        npulse  = 0;
        for (int i = 0; i < 80; i++) begin
            if (trig_pulse) begin
                if (first < 0) first = i;
                else if ((i - last) != 20) gap_bad++;
                last = i;
                npulse++;
            end
            cycle();
        end
        check("per_first_latency", 32'(first),   32'd20);
        check("per_npulse",        32'(npulse),  32'd3);
        check("per_gap_errors",    32'(gap_bad), 32'd0);

        // ---- stop: pulses cease, counter held at 0 ----
        send(8'h01, 32'd0);
        cycle();
        npulse = 0;
        for (int i = 0; i < 45; i++) begin
            if (trig_pulse) npulse++;
            cycle();
        end
        check("stop_npulse", 32'(npulse), 32'd0);
        check("stop_tcnt",   dut.u_trig_timer.tcnt_q, 32'd0);

        // ---- software start with continuous=0 ----
        send(8'h10, 32'd0);
        check("start_pulse_t2", 32'(start_pulse), 32'd1);
        check("start_trig_t2",  32'(trig_pulse),  32'd0);
        cycle();
        check("start_pulse_t3", 32'(start_pulse), 32'd0);
        check("start_trig_t3",  32'(trig_pulse),  32'd1);
        cycle();
        npulse = 0;
        for (int i = 0; i < 30; i++) begin
            if (trig_pulse) npulse++;
            cycle();
        end
        check("start_extra_trig", 32'(npulse), 32'd0);

        // ---- soft reset stretch: 5 cycles, then 0 treated as 1 ----
        send(8'h11, 32'd5);
        n = 0;
        while (dev_rst && n < 300) begin
            n++;
            cycle();
        end
        check("dev_rst_len5", 32'(n), 32'd5);
        repeat (3) cycle();
        send(8'h11, 32'h0000_0100);
        n = 0;
        while (dev_rst && n < 300) begin
            n++;
            cycle();
        end
        check("dev_rst_len0", 32'(n), 32'd1);
        repeat (3) cycle();

        // ---- three back-to-back commands with response stalled ----
        rsp_ready = 1'b0;
        send(8'h04, 32'h111);
        send(8'h04, 32'h222);
        send(8'h04, 32'h333);
`ifdef ETH_CMD_ECHO_EN
        check("pend_drop_cnt",  32'(drop_cnt),  32'd1);
        check("pend_gain_1st",  32'(gain_code), 32'h111);
        check("pend_rsp_valid", 32'(rsp_valid), 32'd1);
        check("pend_rsp_data",  rsp_data,       32'h111);
        check("pend_busy",      32'(busy),      32'd1);
        rsp_ready = 1'b1;
        repeat (3) cycle();
        check("pend_gain_2nd",      32'(gain_code), 32'h222);
        check("pend_rsp_valid_2nd", 32'(rsp_valid), 32'd1);
        check("pend_rsp_data_2nd",  rsp_data,       32'h222);
        repeat (4) cycle();
        check("pend_gain_final", 32'(gain_code), 32'h222);
        check("pend_busy_final", 32'(busy),      32'd0);
        check("pend_drop_final", 32'(drop_cnt),  32'd1);
`else
        check("pend_drop_cnt",  32'(drop_cnt),  32'd0);
        check("pend_gain_last", 32'(gain_code), 32'h333);
        rsp_ready = 1'b1;
        repeat (2) cycle();
`endif

        // ---- reset in the middle of a command ----
        rsp_ready = 1'b0;
        send(8'h04, 32'h5A5);
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        check("mid_rst_rsp_valid", 32'(rsp_valid),  32'd0);
        check("mid_rst_busy",      32'(busy),       32'd0);
        check("mid_rst_gain",      32'(gain_code),  32'h800);
        check("mid_rst_len",       32'(sample_len), 32'd1024);
        check("mid_rst_drop",      32'(drop_cnt),   32'd0);
        repeat (3) cycle();
        check("mid_rst_rsp_gone",  32'(rsp_valid),  32'd0);
        check("mid_rst_idle",      32'(busy),       32'd0);
        rsp_ready = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
